// File: rtl/axis_udp_filter_arb.sv
// ---------------------------------------------------------------------------
// axis_udp_filter_arb
//
// Frame-granular round-robin arbiter that shares one UDP filter datapath
// between NUM_PORTS AXI-Stream sources. A source is granted in IDLE, keeps the
// grant for its whole frame (through tlast), and its beats pass through a
// one-deep output register toward the filter.
//
// Optional feature macro: AXIS_UDP_FILTER_ARB_TIMEOUT_EN
//   When defined, a stall watchdog aborts a frame whose granted source stops
//   presenting data for TIMEOUT_CYCLES cycles: abort_o pulses, a zero-strobe
//   tlast beat is injected downstream, and the rest of the source frame is
//   drained and discarded.
//
// Ports:
//   clk_i, rst_n_i           clock, asynchronous active-low reset
//   en_i                     arbitration enable (gates new grants only)
//   s_axis_*                 NUM_PORTS slave streams, port k at slice k
//   m_axis_*                 single master stream to the filter interface
//   grant_o                  one-hot current grant, zero when idle
//   busy_o                   high while a frame is locked
//   frame_cnt_o              frames forwarded (wrapping 16-bit)
//   abort_o                  one-cycle watchdog abort pulse (0 without macro)
// ---------------------------------------------------------------------------
module axis_udp_filter_arb #(
    parameter int NUM_PORTS      = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   en_i,
    input  logic [NUM_PORTS-1:0]   s_axis_tvalid,
    input  logic [NUM_PORTS*64-1:0] s_axis_tdata,
    input  logic [NUM_PORTS*8-1:0] s_axis_tstrb,
    input  logic [NUM_PORTS-1:0]   s_axis_tlast,
    output logic [NUM_PORTS-1:0]   s_axis_tready,
    output logic                   m_axis_tvalid,
    output logic [63:0]            m_axis_tdata,
    output logic [7:0]             m_axis_tstrb,
    output logic                   m_axis_tlast,
    input  logic                   m_axis_tready,
    output logic [NUM_PORTS-1:0]   grant_o,
    output logic                   busy_o,
    output logic [15:0]            frame_cnt_o,
    output logic                   abort_o
);

    localparam int AXIS_DATA_WIDTH = 64;
    localparam int PTR_W           = $clog2(NUM_PORTS);
    localparam int CW              = PTR_W + 1;

`ifdef AXIS_UDP_FILTER_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {S_IDLE, S_LOCK, S_DRAIN} state_t;
    localparam logic [15:0] STALL_LIMIT = 16'(TIMEOUT_CYCLES - 1);
`else
    typedef enum logic [1:0] {S_IDLE, S_LOCK} state_t;
`endif

    state_t                       r_state, w_nextState;
    logic [PTR_W-1:0]             r_ptr, r_gidx, w_pickIdx, w_nextPtr;
    logic [CW-1:0]                w_cand, w_gPlus;
    logic                         w_pickFound;
    logic [NUM_PORTS-1:0]         r_grant;
    logic                         r_mValid, r_mLast;
    logic [AXIS_DATA_WIDTH-1:0]   r_mData;
    logic [7:0]                   r_mStrb;
    logic [15:0]                  r_frameCnt;
    logic                         w_outFree, w_srcValid, w_srcLast, w_xfer, w_frameEnd;

    assign w_outFree  = !r_mValid || m_axis_tready;
    assign w_srcValid = s_axis_tvalid[r_gidx];
    assign w_srcLast  = s_axis_tlast[r_gidx];
    assign w_xfer     = (r_state == S_LOCK) && w_srcValid && w_outFree;

`ifdef AXIS_UDP_FILTER_ARB_TIMEOUT_EN
    logic [15:0] r_stallCnt;
    logic        r_abort, r_injPend, r_drained, r_mInj;
    logic        w_stallHit, w_drainLast, w_inject, w_drainExit;

    assign w_stallHit  = (r_state == S_LOCK) && !w_srcValid && (r_stallCnt == STALL_LIMIT);
    assign w_drainLast = (r_state == S_DRAIN) && !r_drained && w_srcValid && w_srcLast;
    assign w_inject    = (r_state == S_DRAIN) && r_injPend && w_outFree;
    assign w_drainExit = (r_state == S_DRAIN) && (r_drained || w_drainLast) && (!r_injPend || w_inject);
    assign w_frameEnd  = (w_xfer && w_srcLast) || w_drainExit;
    assign abort_o     = r_abort;
`else
    assign w_frameEnd  = w_xfer && w_srcLast;
    assign abort_o     = 1'b0;
`endif

    // Round-robin search: first requester at or after the pointer, with wrap,
    // plus the pointer value that follows the current grant.
    always_comb begin
        w_pickIdx   = '0;
        w_pickFound = 1'b0;
        w_cand      = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_cand = {1'b0, r_ptr} + CW'(i);
            if (w_cand >= CW'(NUM_PORTS)) w_cand = w_cand - CW'(NUM_PORTS);
            if (!w_pickFound && s_axis_tvalid[w_cand[PTR_W-1:0]]) begin
                w_pickFound = 1'b1;
                w_pickIdx   = w_cand[PTR_W-1:0];
            end
        end
        w_gPlus = {1'b0, r_gidx} + CW'(1);
        if (w_gPlus >= CW'(NUM_PORTS)) w_gPlus = '0;
        w_nextPtr = w_gPlus[PTR_W-1:0];
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_state <= S_IDLE;
        else          r_state <= w_nextState;
    end

    // FSM next state and the per-source ready fan-out. Only the granted port
    // ever sees ready; in DRAIN it is forced high until the frame's tlast.
    always_comb begin
        w_nextState   = r_state;
        s_axis_tready = '0;
        case (r_state)
            S_IDLE: begin
                if (en_i && w_pickFound) w_nextState = S_LOCK;
            end
            S_LOCK: begin
                s_axis_tready[r_gidx] = w_outFree;
                if (w_xfer && w_srcLast) w_nextState = S_IDLE;
`ifdef AXIS_UDP_FILTER_ARB_TIMEOUT_EN
                else if (w_stallHit) w_nextState = S_DRAIN;
`endif
            end
`ifdef AXIS_UDP_FILTER_ARB_TIMEOUT_EN
            S_DRAIN: begin
                s_axis_tready[r_gidx] = !r_drained;
                if (w_drainExit) w_nextState = S_IDLE;
            end
`endif
            default: w_nextState = S_IDLE;
        endcase
    end

    // Grant bookkeeping: latch the winner on leaving IDLE, release it and
    // advance the pointer past it when the frame ends.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_ptr   <= '0;
            r_gidx  <= '0;
            r_grant <= '0;
        end else if (r_state == S_IDLE) begin
            if (en_i && w_pickFound) begin
                r_gidx  <= w_pickIdx;
                r_grant <= NUM_PORTS'(1) << w_pickIdx;
            end
        end else if (w_frameEnd) begin
            r_grant <= '0;
            r_ptr   <= w_nextPtr;
        end
    end

    // One-deep output register; contents only change once the filter side
    // has taken the current beat (or the register is empty).
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_mValid <= 1'b0;
            r_mData  <= '0;
            r_mStrb  <= '0;
            r_mLast  <= 1'b0;
        end else if (w_xfer) begin
            r_mValid <= 1'b1;
            r_mData  <= s_axis_tdata[{r_gidx, 6'd0} +: AXIS_DATA_WIDTH];
            r_mStrb  <= s_axis_tstrb[{r_gidx, 3'd0} +: 8];
            r_mLast  <= w_srcLast;
`ifdef AXIS_UDP_FILTER_ARB_TIMEOUT_EN
        end else if (w_inject) begin
            r_mValid <= 1'b1;
            r_mData  <= '0;
            r_mStrb  <= '0;
            r_mLast  <= 1'b1;
`endif
        end else if (m_axis_tready) begin
            r_mValid <= 1'b0;
        end
    end

`ifdef AXIS_UDP_FILTER_ARB_TIMEOUT_EN
    // Watchdog: counts stalled LOCK cycles, then arms the injected abort beat
    // and tracks whether the stalled frame's tlast has been swallowed yet.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_stallCnt <= '0;
            r_abort    <= 1'b0;
            r_injPend  <= 1'b0;
            r_drained  <= 1'b0;
            r_mInj     <= 1'b0;
        end else begin
            r_abort <= w_stallHit;
            if (r_state != S_LOCK || w_xfer) r_stallCnt <= '0;
            else if (!w_srcValid)            r_stallCnt <= r_stallCnt + 16'd1;
            if (w_stallHit)       r_injPend <= 1'b1;
            else if (w_inject)    r_injPend <= 1'b0;
            if (w_stallHit)       r_drained <= 1'b0;
            else if (w_drainLast) r_drained <= 1'b1;
            if (w_xfer)           r_mInj <= 1'b0;
            else if (w_inject)    r_mInj <= 1'b1;
        end
    end
`endif

    // Frame counter: advances when a real tlast beat is accepted downstream;
    // the watchdog's injected beat is not a forwarded frame.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_frameCnt <= '0;
`ifdef AXIS_UDP_FILTER_ARB_TIMEOUT_EN
        end else if (r_mValid && m_axis_tready && r_mLast && !r_mInj) begin
`else
        end else if (r_mValid && m_axis_tready && r_mLast) begin
`endif
            r_frameCnt <= r_frameCnt + 16'd1;
        end
    end

    assign m_axis_tvalid = r_mValid;
    assign m_axis_tdata  = r_mData;
    assign m_axis_tstrb  = r_mStrb;
    assign m_axis_tlast  = r_mLast;
    assign grant_o       = r_grant;
    assign busy_o        = (r_state != S_IDLE);
    assign frame_cnt_o   = r_frameCnt;

endmodule
